// File: rtl/fpu_addsub.sv
// fpu_addsub: multi-cycle IEEE-754-style adder/subtractor with configurable
// exponent/fraction widths, RNE rounding, subnormals and exception flags.
module fpu_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] input_a,
    input  logic [EXP_W+MAN_W:0] input_b,
    input  logic                 op_sub,
    input  logic                 adder_input_STB,
    output logic                 adder_BUSY,
    output logic [EXP_W+MAN_W:0] output_sum,
    output logic [2:0]           output_flags,
    output logic                 adder_output_STB,
    input  logic                 output_module_BUSY
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;   // significand including hidden bit
    localparam int MW = MAN_W + 4;   // significand plus G, R, S
    localparam int XW = EXP_W + 1;   // working exponent with headroom for overflow

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_ADD    = 3'd3;
    localparam logic [2:0] S_NORM   = 3'd4;
    localparam logic [2:0] S_ROUND  = 3'd5;
    localparam logic [2:0] S_PACK   = 3'd6;
    localparam logic [2:0] S_PUT    = 3'd7;

    // Subnormals (exponent field 0) behave as exponent 1 with hidden bit 0.
    function automatic logic [XW-1:0] eff_exp(input logic [EXP_W-1:0] e);
        eff_exp = (e == {EXP_W{1'b0}}) ? {{(XW-1){1'b0}}, 1'b1} : {1'b0, e};
    endfunction

    logic [2:0]     state_r;
    logic [W-1:0]   a_r, b_r;
    logic           sub_r;
    logic           sa_r, sb_r, nan_r, inv_r, inf_r, inf_sign_r;
    logic [XW-1:0]  ea_r, eb_r, exp_r, e_r, re_r;
    logic [M-1:0]   ma_r, mb_r, rm_r;
    logic [MW-1:0]  big_m_r, small_m_r, m_r;
    logic           sbig_r, ssmall_r, rsign_r, inexact_r;
    logic [MW:0]    sum_r;

    logic [EXP_W-1:0] ea_raw_s, eb_raw_s;
    logic             sb_eff_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s;

    // Field split and special-operand classification of the captured operands.
    always_comb begin
        ea_raw_s = a_r[W-2:MAN_W];
        eb_raw_s = b_r[W-2:MAN_W];
        sb_eff_s = b_r[W-1] ^ sub_r;
        a_nan_s  = (&ea_raw_s) & (|a_r[MAN_W-1:0]);
        b_nan_s  = (&eb_raw_s) & (|b_r[MAN_W-1:0]);
        a_inf_s  = (&ea_raw_s) & ~(|a_r[MAN_W-1:0]);
        b_inf_s  = (&eb_raw_s) & ~(|b_r[MAN_W-1:0]);
    end

    logic          a_big_s, lost_s;
    logic [XW-1:0] diff_s, big_e_s;
    logic [MW-1:0] big_ext_s, small_ext_s, small_sh_s;

    // Alignment: shift the smaller-exponent significand right, folding lost bits into sticky.
    always_comb begin
        a_big_s = (ea_r >= eb_r);
        if (a_big_s) begin
            big_ext_s   = {ma_r, 3'b000};
            small_ext_s = {mb_r, 3'b000};
            diff_s      = ea_r - eb_r;
            big_e_s     = ea_r;
        end else begin
            big_ext_s   = {mb_r, 3'b000};
            small_ext_s = {ma_r, 3'b000};
            diff_s      = eb_r - ea_r;
            big_e_s     = eb_r;
        end
        small_sh_s = small_ext_s >> diff_s;
        lost_s     = 1'b0;
        for (int i = 0; i < MW; i++) begin
            if (32'(i) < {{(32-XW){1'b0}}, diff_s}) lost_s = lost_s | small_ext_s[i];
            else lost_s = lost_s;
        end
        small_sh_s[0] = small_sh_s[0] | lost_s;
    end

    logic        eff_sub_s, sign_s;
    logic [MW:0] sum_s;

    // Magnitude add/subtract; an exact zero is +0 unless both addends were -0.
    always_comb begin
        eff_sub_s = sbig_r ^ ssmall_r;
        if (!eff_sub_s) begin
            sum_s  = {1'b0, big_m_r} + {1'b0, small_m_r};
            sign_s = sbig_r;
        end else if (big_m_r >= small_m_r) begin
            sum_s  = {1'b0, big_m_r - small_m_r};
            sign_s = sbig_r;
        end else begin
            sum_s  = {1'b0, small_m_r - big_m_r};
            sign_s = ssmall_r;
        end
        if (sum_s == {(MW+1){1'b0}}) sign_s = sbig_r & ~eff_sub_s;
        else sign_s = sign_s;
    end

    logic [31:0]   lzc_s, lim_s, shift_s;
    logic [MW-1:0] norm_m_s;
    logic [XW-1:0] norm_e_s;

    // Normalisation; left shift is capped so the exponent never drops below 1.
    always_comb begin
        lzc_s = 32'(MW);
        for (int i = 0; i < MW; i++) begin
            if (sum_r[i]) lzc_s = 32'(MW - 1 - i);
            else lzc_s = lzc_s;
        end
        lim_s   = {{(32-XW){1'b0}}, exp_r} - 32'd1;
        shift_s = (lzc_s < lim_s) ? lzc_s : lim_s;
        if (sum_r[MW]) begin
            norm_m_s = {sum_r[MW:2], sum_r[1] | sum_r[0]};
            norm_e_s = exp_r + {{(XW-1){1'b0}}, 1'b1};
        end else begin
            norm_m_s = sum_r[MW-1:0] << shift_s;
            norm_e_s = exp_r - shift_s[XW-1:0];
        end
    end

    logic          rnd_up_s;
    logic [M:0]    rnd_s;
    logic [M-1:0]  rmant_s;
    logic [XW-1:0] rexp_s;

    // Round to nearest, ties to even.
    always_comb begin
        rnd_up_s = m_r[2] & (m_r[1] | m_r[0] | m_r[3]);
        rnd_s    = {1'b0, m_r[MW-1:3]} + {{M{1'b0}}, rnd_up_s};
        if (rnd_s[M]) begin
            rmant_s = rnd_s[M:1];
            rexp_s  = e_r + {{(XW-1){1'b0}}, 1'b1};
        end else begin
            rmant_s = rnd_s[M-1:0];
            rexp_s  = e_r;
        end
    end

    logic [W-1:0] pack_sum_s;
    logic [2:0]   pack_flags_s;

    // Result encoding with special cases in priority order.
    always_comb begin
        if (nan_r | inv_r) begin
            pack_sum_s   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            pack_flags_s = 3'b100;
        end else if (inf_r) begin
            pack_sum_s   = {inf_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_flags_s = 3'b000;
        end else if (re_r >= {1'b0, {EXP_W{1'b1}}}) begin
            pack_sum_s   = {rsign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_flags_s = 3'b011;
        end else begin
            pack_sum_s   = {rsign_r, rm_r[M-1] ? re_r[EXP_W-1:0] : {EXP_W{1'b0}}, rm_r[MAN_W-1:0]};
            pack_flags_s = {2'b00, inexact_r};
        end
    end

    // Sequencer and per-stage pipeline registers; one operation in flight at a time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;  adder_BUSY <= 1'b0;  adder_output_STB <= 1'b0;
            output_sum <= {W{1'b0}};  output_flags <= 3'b000;
            a_r <= {W{1'b0}};  b_r <= {W{1'b0}};  sub_r <= 1'b0;
            sa_r <= 1'b0;  sb_r <= 1'b0;  nan_r <= 1'b0;  inv_r <= 1'b0;
            inf_r <= 1'b0;  inf_sign_r <= 1'b0;
            ea_r <= {XW{1'b0}};  eb_r <= {XW{1'b0}};  exp_r <= {XW{1'b0}};
            e_r <= {XW{1'b0}};  re_r <= {XW{1'b0}};
            ma_r <= {M{1'b0}};  mb_r <= {M{1'b0}};  rm_r <= {M{1'b0}};
            big_m_r <= {MW{1'b0}};  small_m_r <= {MW{1'b0}};  m_r <= {MW{1'b0}};
            sbig_r <= 1'b0;  ssmall_r <= 1'b0;  rsign_r <= 1'b0;  inexact_r <= 1'b0;
            sum_r <= {(MW+1){1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (adder_input_STB) begin
                        a_r <= input_a;  b_r <= input_b;  sub_r <= op_sub;
                        adder_BUSY <= 1'b1;
                        state_r <= S_UNPACK;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_UNPACK: begin
                    sa_r <= a_r[W-1];  sb_r <= sb_eff_s;
                    ea_r <= eff_exp(ea_raw_s);  eb_r <= eff_exp(eb_raw_s);
                    ma_r <= {|ea_raw_s, a_r[MAN_W-1:0]};
                    mb_r <= {|eb_raw_s, b_r[MAN_W-1:0]};
                    nan_r <= a_nan_s | b_nan_s;
                    inv_r <= a_inf_s & b_inf_s & (a_r[W-1] ^ sb_eff_s);
                    inf_r <= a_inf_s | b_inf_s;
                    inf_sign_r <= a_inf_s ? a_r[W-1] : sb_eff_s;
                    state_r <= S_ALIGN;
                end
                S_ALIGN: begin
                    exp_r <= big_e_s;  big_m_r <= big_ext_s;  small_m_r <= small_sh_s;
                    sbig_r <= a_big_s ? sa_r : sb_r;
                    ssmall_r <= a_big_s ? sb_r : sa_r;
                    state_r <= S_ADD;
                end
                S_ADD: begin
                    sum_r <= sum_s;  rsign_r <= sign_s;
                    state_r <= S_NORM;
                end
                S_NORM: begin
                    m_r <= norm_m_s;  e_r <= norm_e_s;
                    state_r <= S_ROUND;
                end
                S_ROUND: begin
                    rm_r <= rmant_s;  re_r <= rexp_s;
                    inexact_r <= m_r[2] | m_r[1] | m_r[0];
                    state_r <= S_PACK;
                end
                S_PACK: begin
                    output_sum <= pack_sum_s;  output_flags <= pack_flags_s;
                    adder_output_STB <= 1'b1;
                    state_r <= S_PUT;
                end
                S_PUT: begin
                    if (!output_module_BUSY) begin
                        adder_output_STB <= 1'b0;  adder_BUSY <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_PUT;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub.sv
// Directed-vector bench for fpu_addsub (single-precision defaults).
module tb_fpu_addsub;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] input_a = 32'd0, input_b = 32'd0;
    logic        op_sub = 1'b0, adder_input_STB = 1'b0, output_module_BUSY = 1'b0;
    logic        adder_BUSY, adder_output_STB;
    logic [31:0] output_sum;
    logic [2:0]  output_flags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic [2:0]  flags;
        string       name;
    } vec_t;

    vec_t vecs[12];

    fpu_addsub dut (
        .clk(clk), .rst(rst), .input_a(input_a), .input_b(input_b), .op_sub(op_sub),
        .adder_input_STB(adder_input_STB), .adder_BUSY(adder_BUSY),
        .output_sum(output_sum), .output_flags(output_flags),
        .adder_output_STB(adder_output_STB), .output_module_BUSY(output_module_BUSY)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Wait (bounded) for the output strobe; returns edges counted since the accepting edge.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!adder_output_STB && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input vec_t v);
        int cyc;
        @(negedge clk);
        input_a = v.a; input_b = v.b; op_sub = v.sub; adder_input_STB = 1'b1;
        @(posedge clk); #1;
        adder_input_STB = 1'b0;
        input_a = 32'hDEADBEEF; input_b = 32'h12345678; op_sub = ~v.sub;
        check({v.name, " busy"}, {31'd0, adder_BUSY}, 32'd1);
        wait_out(cyc);
        check({v.name, " latency"}, cyc, 32'd6);
        check({v.name, " sum"}, output_sum, v.sum);
        check({v.name, " flags"}, {29'd0, output_flags}, {29'd0, v.flags});
        @(posedge clk); #1;
        check({v.name, " handoff"}, {30'd0, adder_output_STB, adder_BUSY}, 32'd0);
    endtask

    initial begin
        int cyc;
        vecs[0]  = '{32'h40800000, 32'h40A00000, 1'b1, 32'hBF800000, 3'b000, "4-5"};
        vecs[1]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, "tie_even"};
        vecs[2]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001, "round_up"};
        vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, "overflow"};
        vecs[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, "inf-inf"};
        vecs[5]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000, "denorm"};
        vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, "neg_zero"};
        vecs[7]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, "1-1"};
        vecs[8]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, "inf+1"};
        vecs[9]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, "nan"};
        vecs[10] = '{32'h3FC00000, 32'hBF000000, 1'b0, 32'h3F800000, 3'b000, "1.5+-0.5"};
        vecs[11] = '{32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 3'b000, "denorm_to_norm"};

        #12;
        check("reset outputs", {output_sum[28:0], output_flags}, 32'd0);
        check("reset ctrl", {30'd0, adder_BUSY, adder_output_STB}, 32'd0);
        @(negedge clk); rst = 1'b1;

        // Held STB: second pair is picked up at k+8 without being lost.
        input_a = 32'h40000000; input_b = 32'h40400000; op_sub = 1'b0; adder_input_STB = 1'b1;
        @(posedge clk); #1;
        check("held busy@k", {31'd0, adder_BUSY}, 32'd1);
        input_a = 32'h40800000; input_b = 32'h40A00000;
        wait_out(cyc);
        check("held latency1", cyc, 32'd6);
        check("held sum1", output_sum, 32'h40A00000);
        check("held flags1", {29'd0, output_flags}, 32'd0);
        @(posedge clk); #1;
        check("held k+7", {30'd0, adder_BUSY, adder_output_STB}, 32'd0);
        @(posedge clk); #1;
        check("held k+8 accept", {31'd0, adder_BUSY}, 32'd1);
        adder_input_STB = 1'b0;
        wait_out(cyc);
        check("held latency2", cyc, 32'd6);
        check("held sum2", output_sum, 32'h41100000);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // Backpressure in PUT for 5 cycles with a new STB waiting.
        @(negedge clk);
        output_module_BUSY = 1'b1;
        input_a = 32'h40000000; input_b = 32'h40400000; op_sub = 1'b0; adder_input_STB = 1'b1;
        @(posedge clk); #1;
        input_a = 32'h40800000; input_b = 32'h40A00000; op_sub = 1'b1;
        wait_out(cyc);
        check("bp latency", cyc, 32'd6);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp sum stable", output_sum, 32'h40A00000);
            check("bp ctrl", {29'd0, output_flags, adder_output_STB, adder_BUSY} , 32'd3);
        end
        output_module_BUSY = 1'b0;
        @(posedge clk); #1;
        check("bp release", {30'd0, adder_output_STB, adder_BUSY}, 32'd0);
        @(posedge clk); #1;
        check("bp accept", {31'd0, adder_BUSY}, 32'd1);
        adder_input_STB = 1'b0;
        wait_out(cyc);
        check("bp second", output_sum, 32'hBF800000);
        @(posedge clk); #1;

        // Reset mid-operation at k+3.
        @(negedge clk);
        input_a = 32'h3F800000; input_b = 32'h3F800000; op_sub = 1'b0; adder_input_STB = 1'b1;
        @(posedge clk); #1;
        adder_input_STB = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst sum", output_sum, 32'd0);
        check("midrst ctrl", {27'd0, output_flags, adder_BUSY, adder_output_STB}, 32'd0);
        @(negedge clk); rst = 1'b1;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (adder_output_STB) cyc++;
        end
        check("midrst no STB", cyc, 32'd0);
        run_op('{32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 3'b000, "after_reset"});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/fpu_addsub.md
# fpu_addsub

Parametrised IEEE-754-style floating-point adder/subtractor. It is the successor to the single-precision `adder`: configurable exponent and mantissa widths, a runtime add/subtract select, round-to-nearest-even with guard/round/sticky, subnormal support and exception flags. It keeps the STB/BUSY handshake on both input and output, so it drops into the same slots between an operand source and an output module.

## Interface
- `EXP_W`, default 8: exponent field width (≥3).
- `MAN_W`, default 23: stored mantissa (fraction) width (≥2); word width `W = 1+EXP_W+MAN_W`.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `input_a`  in  W  operand A.
- `input_b`  in  W  operand B.
- `op_sub`  in  1  0: A+B; 1: A−B. Sampled with the operands.
- `adder_input_STB`  in  1  operands valid.
- `adder_BUSY`  out  1  high while an operation is in flight; operands are not accepted.
- `output_sum`  out  W  result.
- `output_flags`  out  3  [2] invalid, [1] overflow, [0] inexact; valid with `output_sum`.
- `adder_output_STB`  out  1  result valid.
- `output_module_BUSY`  in  1  downstream not ready.

## Operation
- Transaction: rising edge with `adder_input_STB=1 && adder_BUSY=0`. Operands and `op_sub` are captured into internal registers. Later changes on the inputs are ignored until the next transaction.
- FSM: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → PACK → PUT → IDLE. Each state lasts exactly one cycle except PUT, which holds while `output_module_BUSY=1`.
- UNPACK:
  - Split each operand into sign, exponent and fraction.
  - Subtract mode inverts B's sign.
  - Exponent 0 is treated as a subnormal: hidden bit 0, effective exponent 1.
  - Classify zero, subnormal, normal, inf and NaN.
- ALIGN: single-cycle barrel right-shift of the smaller-exponent mantissa by the exponent difference. Shifted-out bits OR into sticky. A shift of MAN_W+3 or more leaves only sticky.
- ADD: mantissas carry MAN_W+1 significant bits plus G, R and S.
  - Effective add: sum, one carry bit.
  - Effective subtract: larger magnitude minus smaller, with the sign taken from the larger.
- NORM:
  - On carry out, right-shift by 1 (sticky accumulates) and increment the exponent.
  - Otherwise, left-shift by the leading-zero count in one cycle, limited so the exponent does not go below 1. Results below that limit remain subnormal (encoded exponent 0).
- ROUND: round to nearest, ties to even using G/R/S.
  - Rounding may carry out, which renormalises and increments the exponent.
  - `inexact` = G|R|S before rounding.
- PACK and special cases, in priority order:
  - Any NaN input, or inf−inf (effective), gives canonical qNaN {0, all-ones exp, MSB fraction 1, rest 0} with `invalid`=1.
  - Otherwise any inf gives that inf.
  - Exponent ≥ all-ones gives ±inf with `overflow`=1 and `inexact`=1.
  - An exact zero sum gives +0, except (−0)+(−0) gives −0.
  - Special-case results clear `inexact`.
- Special cases still traverse every state, so latency is fixed.

## Timing
- Reset (`rst` low, asynchronous, any state, including mid-operation):
  - State → IDLE.
  - `adder_BUSY`=0, `adder_output_STB`=0, `output_sum`=0, `output_flags`=0.
  - An in-flight result is discarded.
  - The first transaction is possible on the first rising edge after `rst` deasserts.
- Transaction at edge k:
  - `adder_BUSY`=1 from edge k.
  - `adder_output_STB`=1, with `output_sum` and `output_flags` valid, from edge k+6.
- PUT: `output_sum`/`output_flags` stay stable and `adder_output_STB` stays high on every edge where `output_module_BUSY=1`.
- Handoff: the first edge in PUT with `output_module_BUSY=0` completes the output transfer. From that edge `adder_output_STB`=0 and `adder_BUSY`=0.
- Throughput: with no backpressure, the next transaction is at edge k+8, i.e. one operation per 8 cycles.
- While `adder_BUSY`=1, `adder_input_STB` has no effect. No input is lost: a held STB is accepted once BUSY falls.
- `output_sum` keeps its last value after handoff.

## Test plan
- 0x40000000 + 0x40400000, op_sub=0, STB held with second pair 0x40800000/0x40A00000, output_module_BUSY=0:
  - 0x40A00000, flags 000, at k+6.
  - Second pair accepted at k+8, giving 0x41100000.
- 0x40800000 − 0x40A00000 (op_sub=1) → 0xBF800000, flags 000.
- Rounding, flags 001 in each case:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000.
  - 0x3F800000 + 0x33C00000 → 0x3F800001.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags 011.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, flags 100.
  - 0x00000001 + 0x00000001 → 0x00000002, flags 000.
- Backpressure: output_module_BUSY=1 for 5 cycles in PUT.
  - Sum and flags stay stable with STB high, and adder_BUSY stays 1.
  - The new STB is not accepted until the output is released.
- Reset mid-operation: assert rst low at k+3.
  - All outputs go to 0 immediately (asynchronously).
  - No output STB appears.
  - The next transaction completes normally.
